rr_select_arbiter: RTL and testbench
====================================

# rr_select_arbiter

Round-robin arbiter that shares one 3-to-8 select decoder among eight requesters. It registers a 3-bit select code plus an active-high decoder enable, and returns a one-hot grant to the winner. Each grant ends on requester release or on a hold timeout, followed by a guaranteed dead gap (break-before-make) before the next select drives. It sits directly upstream of the decoder and owns its A/B/C and enable inputs.

## Interface

- `MAX_HOLD`, default 16: maximum cycles a grant may be held; range 1..255.
- `GAP_CYCLES`, default 1: dead cycles with the decoder disabled between grants; range 1..15.

- `CLK` input, 1 bit: sole clock, rising edge.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `REQ` input, 8 bits: request per requester, level, held high while using the resource.
- `GNT` output, 8 bits: one-hot grant, registered.
- `SEL` output, 3 bits: binary index of granted requester, drives decoder {C,B,A}, registered.
- `SEL_EN` output, 1 bit: decoder enable, high only in GRANT, registered.
- `BUSY` output, 1 bit: high in GRANT or GAP.
- `TIMEOUT` output, 1 bit: one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation

- **Reset values:** state IDLE, `GNT`=0, `SEL`=0, `SEL_EN`=0, `BUSY`=0, `TIMEOUT`=0, `last_ptr`=7, hold counter=0, gap counter=0.
- **State machine:** IDLE, GRANT, GAP.
- **IDLE:**
  - If `REQ`≠0, pick the winner: the first set bit scanning upward from `last_ptr`+1, modulo 8.
  - Next cycle enters GRANT with `GNT`=onehot(winner), `SEL`=winner, `SEL_EN`=1.
  - Update `last_ptr`=winner and clear the hold counter.
- **GRANT:**
  - Hold counter increments each cycle.
  - If `REQ[SEL]`=0, go to GAP (normal release).
  - Else if hold counter = `MAX_HOLD`-1, go to GAP and pulse `TIMEOUT` (revoke).
  - Release takes priority over timeout in the same cycle; `TIMEOUT` stays 0.
  - `REQ` changes on other bits are ignored while in GRANT.
- **GAP:**
  - `GNT`=0, `SEL_EN`=0. `SEL` holds its last value so the decoder inputs do not glitch.
  - Stay `GAP_CYCLES` cycles, then go to IDLE.
- **Fairness:**
  - A requester that timed out and keeps `REQ` high is eligible again, but only after every other active requester has been served once.
  - The pointer advances only on grant, never on timeout alone.
- **Invariant:** `GNT` is never multi-hot, and is never nonzero while `SEL_EN`=0. `GNT`≠0 exactly when `SEL_EN`=1.
- **Width rules:** the hold counter is 8 bits and saturates (never wraps). The gap counter is 4 bits. `SEL` wraps 7→0 during the pointer search.

## Timing

- Request to grant: `REQ` sampled high in IDLE at edge n gives `GNT`/`SEL_EN` high after edge n+1 (1-cycle latency).
- Grant duration:
  - Normal release: `REQ[SEL]` sampled low at edge m gives `SEL_EN` low after edge m.
  - Timeout: the grant lasts exactly `MAX_HOLD` cycles.
- Back-to-back minimum: the next grant appears `GAP_CYCLES`+1 cycles after `SEL_EN` falls (GAP cycles, then one IDLE arbitration cycle).
- `TIMEOUT` is high for exactly the first GAP cycle.
- `RESET` asserted in any state: all outputs return to reset values at the next edge. No gap is inserted; the decoder is disabled immediately.
- `REQ` is assumed synchronous to `CLK`. No internal synchronizers.

## Structure

- **Shared package `sel_arb_pkg`:**
  - State enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2).
  - `NUM_REQ`=8, `IDX_W`=3.
  - onehot/index conversion function.
- **Sub-module `rr_pick`:** combinational rotating priority encoder. Inputs `req[7:0]` and `ptr[2:0]`; outputs `idx[2:0]` and `valid`. The top level holds the FSM and counters.

## Test plan

- **Single request:** reset, then `REQ`=8'h04. Required: `GNT`=8'h04, `SEL`=2, `SEL_EN`=1 after one cycle. Drop `REQ` → `SEL_EN`=0 next edge; `BUSY` high for exactly `GAP_CYCLES`.
- **Round-robin:** `REQ`=8'hFF held, each requester releasing after 2 cycles. Required grant order is 0,1,2…7,0. Check `SEL` matches the `GNT` index each time and that no two grants are adjacent without a gap.
- **Timeout:** `MAX_HOLD`=4, `REQ`=8'h01 and 8'h10 held forever. Required: grant 0 lasts 4 cycles, `TIMEOUT` pulses once, then grant 4, then grant 0 again.
- **Simultaneous release and timeout:** requester drops on the last hold cycle. Required: `TIMEOUT`=0, normal GAP.
- **Reset mid-grant:** assert `RESET` while `GNT`=8'h20. Required: next edge gives `GNT`=0, `SEL_EN`=0, `SEL`=0; the first grant after reset goes to the lowest active index ≥0.
- **Wrap and sparse:** `last_ptr`=6 and `REQ`=8'h41. Required: requester 0 granted before 6.

Source files
------------

// File: rtl/sel_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter and its
// rotating priority encoder.
package sel_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Lowest set bit wins; callers only pass one-hot or zero vectors.
    function automatic logic [IDX_W-1:0] to_index(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (oh[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request strictly after ptr, wrapping,
// with ptr itself considered last.
module rr_pick
    import sel_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin owner of a shared 3-to-8 decoder: registered select code and
// enable, bounded hold time, and a dead gap between consecutive grants.
module rr_select_arbiter
    import sel_arb_pkg::*;
#(
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic [2:0] SEL,
    output logic       SEL_EN,
    output logic       BUSY,
    output logic       TIMEOUT
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] last_ptr;
    logic [7:0]       hold_cnt;
    logic [3:0]       gap_cnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick u_pick (
        .req   (REQ),
        .ptr   (last_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            GNT      <= '0;
            SEL      <= '0;
            SEL_EN   <= 1'b0;
            BUSY     <= 1'b0;
            TIMEOUT  <= 1'b0;
            last_ptr <= 3'd7;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    TIMEOUT <= 1'b0;
                    if (pick_valid) begin
                        state    <= GRANT;
                        GNT      <= onehot(pick_idx);
                        SEL      <= pick_idx;
                        SEL_EN   <= 1'b1;
                        BUSY     <= 1'b1;
                        last_ptr <= pick_idx;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
                    // Release beats timeout: TIMEOUT only when the owner still wants it.
                    if (!REQ[SEL] || hold_cnt == HOLD_LAST) begin
                        state   <= GAP;
                        GNT     <= '0;
                        SEL_EN  <= 1'b0;
                        gap_cnt <= '0;
                        TIMEOUT <= REQ[SEL];
                    end
                end
                GAP: begin
                    // SEL is left untouched so the decoder inputs stay quiet.
                    TIMEOUT <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    GNT     <= '0;
                    SEL_EN  <= 1'b0;
                    BUSY    <= 1'b0;
                    TIMEOUT <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed scenarios plus randomized traffic, each cycle checked against a
// behavioural model of grant ownership, hold time and gap length.
module tb_rr_select_arbiter;
    import sel_arb_pkg::*;

    localparam int MH = 4;
    localparam int GC = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] REQ = '0;
    logic [7:0] GNT;
    logic [2:0] SEL;
    logic       SEL_EN, BUSY, TIMEOUT;

    int total = 0;
    int bad   = 0;

    // Model: current owner (-1 none), cycles held, gap cycles remaining.
    int m_owner = -1, m_held = 0, m_gap = 0, m_last = 7, m_sel = 0;
    bit m_to = 0;

    rr_select_arbiter #(.MAX_HOLD(MH), .GAP_CYCLES(GC)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT), .SEL(SEL),
        .SEL_EN(SEL_EN), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    function automatic void model_step(input bit rst, input logic [7:0] r);
        m_to = 0;
        if (rst) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_last = 7; m_sel = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (!r[m_owner]) begin
                m_owner = -1; m_gap = GC;
            end else if (m_held == MH) begin
                m_owner = -1; m_gap = GC; m_to = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (r != 0) begin
            for (int k = 1; k <= 8; k++) begin
                int w;
                w = (m_last + k) % 8;
                if (r[w]) begin
                    m_owner = w; m_sel = w; m_last = w; m_held = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        check("gnt", 32'(GNT), 32'(eg));
        check("sel", 32'(SEL), 32'(m_sel));
        check("sel_en", 32'(SEL_EN), 32'(m_owner >= 0));
        check("busy", 32'(BUSY), 32'(m_owner >= 0 || m_gap > 0));
        check("timeout", 32'(TIMEOUT), 32'(m_to));
    endtask

    task automatic tick(input logic [7:0] r, input bit rst);
        REQ = r;
        RESET = rst;
        @(posedge CLK);
        model_step(rst, r);
        #1;
        check_all();
    endtask

    task automatic wait_grant(input logic [7:0] r, output int n);
        n = 0;
        while (!SEL_EN && n < 20) begin
            tick(r, 1'b0);
            n++;
        end
        check("wait_grant", 32'(SEL_EN), 32'd1);
    endtask

    initial begin
        int n, bcnt, len0, tos;
        logic [2:0] s;
        logic prev_en;
        logic [7:0] r;
        int starts[$];

        // Reset and single request
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b1);
        check("rst_gnt", 32'(GNT), 32'h0);
        check("rst_en", 32'(SEL_EN), 32'h0);
        tick(8'h04, 1'b0);
        check("single_gnt", 32'(GNT), 32'h04);
        check("single_sel", 32'(SEL), 32'd2);
        tick(8'h04, 1'b0);
        tick(8'h00, 1'b0);
        check("single_rel", 32'(SEL_EN), 32'd0);
        bcnt = 0;
        while (BUSY && bcnt < 10) begin
            bcnt++;
            tick(8'h00, 1'b0);
        end
        check("single_busy_len", 32'(bcnt), 32'(GC));

        // Round-robin with all requesting, each releasing after 2 cycles
        tick(8'h00, 1'b1);
        for (int g = 0; g < 9; g++) begin
            wait_grant(8'hFF, n);
            if (g > 0) check("rr_gap", 32'(n), 32'(GC + 1));
            check("rr_order", 32'(SEL), 32'(g % 8));
            check("rr_gnt_idx", 32'(to_index(GNT)), 32'(SEL));
            s = SEL;
            tick(8'hFF, 1'b0);
            tick(8'hFF & ~onehot(s), 1'b0);
        end

        // Timeout with two persistent requesters
        tick(8'h00, 1'b1);
        prev_en = 1'b0; len0 = 0; tos = 0;
        for (int c = 0; c < 22; c++) begin
            tick(8'h11, 1'b0);
            if (SEL_EN && !prev_en) starts.push_back(int'(SEL));
            if (SEL_EN && starts.size() == 1) len0++;
            if (TIMEOUT) tos++;
            prev_en = SEL_EN;
        end
        check("to_nstarts", 32'(starts.size() >= 3), 32'd1);
        if (starts.size() >= 3) begin
            check("to_first", 32'(starts[0]), 32'd0);
            check("to_second", 32'(starts[1]), 32'd4);
            check("to_third", 32'(starts[2]), 32'd0);
        end
        check("to_len", 32'(len0), 32'(MH));
        check("to_pulses", 32'(tos), 32'd3);

        // Release on the last hold cycle: no timeout
        tick(8'h00, 1'b1);
        tick(8'h01, 1'b0);
        for (int c = 0; c < MH - 1; c++) tick(8'h01, 1'b0);
        tick(8'h00, 1'b0);
        check("sim_to", 32'(TIMEOUT), 32'd0);
        check("sim_busy", 32'(BUSY), 32'd1);
        for (int c = 0; c < 4; c++) tick(8'h00, 1'b0);

        // Reset mid-grant
        tick(8'h20, 1'b0);
        check("mid_gnt", 32'(GNT), 32'h20);
        tick(8'h20, 1'b1);
        check("mid_rst_gnt", 32'(GNT), 32'h0);
        check("mid_rst_sel", 32'(SEL), 32'h0);
        check("mid_rst_en", 32'(SEL_EN), 32'h0);
        tick(8'h24, 1'b0);
        check("mid_first", 32'(SEL), 32'd2);
        for (int c = 0; c < 4; c++) tick(8'h00, 1'b0);

        // Wrap and sparse from last_ptr = 6
        tick(8'h00, 1'b1);
        tick(8'h40, 1'b0);
        check("wrap_six", 32'(SEL), 32'd6);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h41, 1'b0);
        check("wrap_zero", 32'(SEL), 32'd0);
        tick(8'h40, 1'b0);
        tick(8'h40, 1'b0);
        tick(8'h40, 1'b0);
        tick(8'h41, 1'b0);
        check("wrap_back", 32'(SEL), 32'd6);

        // Randomized sticky traffic with occasional reset
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            r = r ^ 8'($urandom & $urandom & $urandom);
            tick(r, $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
